// File: rtl/rv_mul_seq.sv
// Sequential unsigned multiplier: one DIGIT x DIGIT partial product per cycle.
// Mode 0 gives the low XLEN bits. Mode 1 gives the full 2*XLEN-bit product.
module rv_mul_seq #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned DIGIT = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            mode,
   input  logic            abort,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result_lo,
   output logic [XLEN-1:0] result_hi
);

   localparam int unsigned N  = XLEN / DIGIT;
   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] Last = CW'(N - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e              state_q, state_d;
   logic [XLEN-1:0]     a_q, a_d, b_q, b_d;
   logic                mode_q, mode_d;
   logic [2*XLEN-1:0]   acc_q, acc_d;
   logic [CW-1:0]       i_q, i_d, j_q, j_d;
   logic [XLEN-1:0]     lo_q, lo_d, hi_q, hi_d;
   logic                busy_q, done_q;

   logic [DIGIT-1:0]    a_dig, b_dig;
   logic [2*DIGIT-1:0]  prod;
   logic [2*XLEN-1:0]   pp;
   int unsigned         shamt;
   logic                last_pair, row_end;

   assign a_dig = a_q[i_q*DIGIT +: DIGIT];
   assign b_dig = b_q[j_q*DIGIT +: DIGIT];
   assign prod  = a_dig * b_dig;
   assign shamt = (int'(i_q) + int'(j_q)) * DIGIT;
   assign pp    = (2*XLEN)'(prod) << shamt;

   // Mode 0 only visits pairs with i+j <= N-1, so each row ends at j = N-1-i.
   assign last_pair = mode_q ? (i_q == Last && j_q == Last) : (i_q == Last);
   assign row_end   = mode_q ? (j_q == Last) : (j_q == Last - i_q);

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      mode_d  = mode_q;
      acc_d   = acc_q;
      i_d     = i_q;
      j_d     = j_q;
      lo_d    = lo_q;
      hi_d    = hi_q;
      unique case (state_q)
         StIdle, StDone: begin
            state_d = StIdle;
            // abort beats a simultaneous start
            if (start && !abort) begin
               state_d = StRun;
               a_d     = a;
               b_d     = b;
               mode_d  = mode;
               acc_d   = '0;
               i_d     = '0;
               j_d     = '0;
            end
         end
         StRun: begin
            if (abort) begin
               state_d = StIdle;
            end else begin
               acc_d = acc_q + pp;
               if (last_pair) begin
                  state_d = StDone;
                  lo_d    = acc_d[XLEN-1:0];
                  hi_d    = mode_q ? acc_d[2*XLEN-1:XLEN] : '0;
               end else if (row_end) begin
                  i_d = i_q + 1'b1;
                  j_d = '0;
               end else begin
                  j_d = j_q + 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         mode_q  <= 1'b0;
         acc_q   <= '0;
         i_q     <= '0;
         j_q     <= '0;
         lo_q    <= '0;
         hi_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         mode_q  <= mode_d;
         acc_q   <= acc_d;
         i_q     <= i_d;
         j_q     <= j_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
         busy_q  <= (state_d == StRun);
         done_q  <= (state_d == StDone);
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign result_lo = lo_q;
   assign result_hi = hi_q;

endmodule
